// File: rtl/alu_seq_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits and record the quotient bit.
module alu_div_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] quo_next
);

    logic [W:0] trial;
    logic [W:0] diff;
    logic       fits;

    // rem < divisor always holds, so the top bit of diff is a clean borrow flag
    always_comb begin
        trial    = {rem, quo[W-1]};
        diff     = trial - {1'b0, divisor};
        fits     = ~diff[W];
        rem_next = fits ? diff[W-1:0] : trial[W-1:0];
        quo_next = {quo[W-2:0], fits};
    end

endmodule

// File: rtl/alu_seq_param.sv
// W-bit sequential ALU (add/sub/mul/div) behind a start/busy/done handshake;
// multi-cycle mul and div share one work register.
module alu_seq_param
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     opcode,
    input  logic [W-1:0]   portA,
    input  logic [W-1:0]   portB,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic           neg,
    output logic           div0
);

    localparam int CNT_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_t state;
    state_t state_next;

    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [1:0]       op_reg;
    logic [CNT_W-1:0] cnt;
    logic [2*W:0]     work;

    logic             accept;
    logic             finish;
    logic [W:0]       add_sum;
    logic [W:0]       sub_diff;
    logic [W:0]       mul_sum;
    logic [2*W:0]     mul_next;
    logic [W-1:0]     rem_next;
    logic [W-1:0]     quo_next;
    logic [2*W-1:0]   fin_result;

    alu_div_step #(.W(W)) u_div_step (
        .rem      (work[2*W-1:W]),
        .quo      (work[W-1:0]),
        .divisor  (b_reg),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Mul keeps {partial sum, multiplier} in work; each step adds A when the
    // multiplier LSB is set and shifts the whole pair right by one.
    always_comb begin
        mul_sum  = work[2*W:W] + {1'b0, {W{work[0]}} & a_reg};
        mul_next = {mul_sum, work[W-1:0]} >> 1;
    end

    always_comb begin
        add_sum    = {1'b0, a_reg} + {1'b0, b_reg};
        sub_diff   = {1'b0, a_reg} - {1'b0, b_reg};
        finish     = 1'b0;
        fin_result = '0;
        case (op_reg)
            OP_ADD: begin
                finish     = 1'b1;
                fin_result = {{(W-1){1'b0}}, add_sum};
            end
            OP_SUB: begin
                finish     = 1'b1;
                fin_result = {{(W-1){sub_diff[W]}}, sub_diff};
            end
            OP_MUL: begin
                finish     = (cnt == '0);
                fin_result = mul_next[2*W-1:0];
            end
            default: begin
                if (b_reg == '0) begin
                    finish     = 1'b1;
                    fin_result = {a_reg, {W{1'b1}}};
                end else begin
                    finish     = (cnt == '0);
                    fin_result = {rem_next, quo_next};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE accepts a new start directly so back-to-back ops lose no cycle
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (finish) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= OP_ADD;
            cnt    <= '0;
            work   <= '0;
            result <= '0;
            neg    <= 1'b0;
            div0   <= 1'b0;
        end else if (accept) begin
            a_reg  <= portA;
            b_reg  <= portB;
            op_reg <= opcode;
            cnt    <= CNT_LAST;
            work   <= {{(W+1){1'b0}}, (opcode == OP_DIV) ? portA : portB};
            result <= '0;
            neg    <= 1'b0;
            div0   <= 1'b0;
        end else if (state == ST_RUN) begin
            if (finish) begin
                result <= fin_result;
                neg    <= (op_reg == OP_SUB) && (a_reg < b_reg);
                div0   <= (op_reg == OP_DIV) && (b_reg == '0);
                cnt    <= '0;
            end else begin
                cnt  <= cnt - CNT_W'(1);
                work <= (op_reg == OP_MUL) ? mul_next : {1'b0, rem_next, quo_next};
            end
        end else begin
            cnt <= '0;
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_alu_seq_param.sv
// Randomised and directed checks of alu_seq_param at W=4 and W=8 against an
// arithmetic reference model.
module tb_alu_seq_param;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_drv;
    logic        sel_wide;
    logic [1:0]  op_drv;
    logic [7:0]  a_drv;
    logic [7:0]  b_drv;

    logic        start4, start8;
    logic        busy4, done4, neg4, div04;
    logic [7:0]  result4;
    logic        busy8, done8, neg8, div08;
    logic [15:0] result8;

    logic        busy_o, done_o, neg_o, div0_o;
    logic [15:0] result_o;

    int pass_count  = 0;
    int total_count = 0;

    always #5 clk = ~clk;

    assign start4   = start_drv & ~sel_wide;
    assign start8   = start_drv & sel_wide;
    assign busy_o   = sel_wide ? busy8 : busy4;
    assign done_o   = sel_wide ? done8 : done4;
    assign neg_o    = sel_wide ? neg8 : neg4;
    assign div0_o   = sel_wide ? div08 : div04;
    assign result_o = sel_wide ? result8 : {8'h00, result4};

    alu_seq_param #(.W(4)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .start  (start4),
        .opcode (op_drv),
        .portA  (a_drv[3:0]),
        .portB  (b_drv[3:0]),
        .busy   (busy4),
        .done   (done4),
        .result (result4),
        .neg    (neg4),
        .div0   (div04)
    );

    alu_seq_param #(.W(8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .start  (start8),
        .opcode (op_drv),
        .portA  (a_drv),
        .portB  (b_drv),
        .busy   (busy8),
        .done   (done8),
        .result (result8),
        .neg    (neg8),
        .div0   (div08)
    );

    task automatic check_output(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_result(input int w, input logic [1:0] op, input int a, input int b);
        int m2;
        m2 = (1 << (2 * w)) - 1;
        case (op)
            OP_ADD:  return 16'(a + b);
            OP_SUB:  return 16'((a - b) & m2);
            OP_MUL:  return 16'(a * b);
            default: begin
                if (b == 0) return 16'((a << w) | ((1 << w) - 1));
                return 16'(((a % b) << w) | (a / b));
            end
        endcase
    endfunction

    function automatic int model_latency(input int w, input logic [1:0] op, input int b);
        if (op == OP_ADD || op == OP_SUB) return 1;
        if (op == OP_DIV && b == 0) return 1;
        return w;
    endfunction

    // Runs one operation from IDLE; poke fires a start with junk operands while busy
    task automatic apply_stimulus(input bit wide, input logic [1:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input bit poke);
        int          w;
        int          ai;
        int          bi;
        int          lat;
        bit          seen;
        bit          hidden_ok;
        bit          busy_ok;
        logic [15:0] exp;
        w         = wide ? 8 : 4;
        ai        = wide ? int'(a) : int'(a[3:0]);
        bi        = wide ? int'(b) : int'(b[3:0]);
        exp       = model_result(w, op, ai, bi);
        seen      = 1'b0;
        lat       = 0;
        hidden_ok = 1'b1;
        busy_ok   = 1'b1;

        sel_wide  = wide;
        start_drv = 1'b1;
        op_drv    = op;
        a_drv     = 8'(ai);
        b_drv     = 8'(bi);
        @(posedge clk); #1;
        check_output("busy_after_start", 16'(busy_o), 16'd1);
        check_output("result_cleared", result_o, 16'd0);
        start_drv = poke;
        op_drv    = 2'($urandom);
        a_drv     = 8'($urandom);
        b_drv     = 8'($urandom);

        for (int i = 1; i <= 3 * w && !seen; i++) begin
            @(posedge clk); #1;
            start_drv = 1'b0;
            if (done_o) begin
                seen = 1'b1;
                lat  = i;
            end else begin
                if (result_o != 16'd0) hidden_ok = 1'b0;
                if (!busy_o) busy_ok = 1'b0;
            end
        end
        check_output("done_seen", 16'(seen), 16'd1);
        check_output("latency", 16'(lat), 16'(model_latency(w, op, bi)));
        check_output("result", result_o, exp);
        check_output("neg", 16'(neg_o), 16'(op == OP_SUB && ai < bi));
        check_output("div0", 16'(div0_o), 16'(op == OP_DIV && bi == 0));
        check_output("busy_at_done", 16'(busy_o), 16'd0);
        check_output("partial_hidden", 16'(hidden_ok), 16'd1);
        check_output("busy_while_run", 16'(busy_ok), 16'd1);

        @(posedge clk); #1;
        check_output("done_pulse", 16'(done_o), 16'd0);
        check_output("result_held", result_o, exp);
    endtask

    initial begin
        bit no_done;

        rst       = 1'b0;
        start_drv = 1'b0;
        sel_wide  = 1'b0;
        op_drv    = OP_ADD;
        a_drv     = '0;
        b_drv     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_busy", 16'(busy4), 16'd0);
        check_output("reset_done", 16'(done4), 16'd0);
        check_output("reset_result", {8'h00, result4}, 16'd0);
        check_output("reset_flags", {14'd0, neg4, div04}, 16'd0);
        check_output("reset_result8", result8, 16'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        apply_stimulus(1'b0, OP_ADD, 8'd15, 8'd15, 1'b0);
        apply_stimulus(1'b0, OP_SUB, 8'd3, 8'd5, 1'b0);
        apply_stimulus(1'b0, OP_SUB, 8'd5, 8'd3, 1'b0);
        apply_stimulus(1'b0, OP_MUL, 8'd13, 8'd11, 1'b0);
        apply_stimulus(1'b0, OP_DIV, 8'd14, 8'd4, 1'b0);
        apply_stimulus(1'b0, OP_DIV, 8'd9, 8'd0, 1'b0);
        apply_stimulus(1'b0, OP_MUL, 8'd13, 8'd11, 1'b1);
        apply_stimulus(1'b0, OP_DIV, 8'd15, 8'd1, 1'b1);
        apply_stimulus(1'b1, OP_MUL, 8'd255, 8'd255, 1'b0);
        apply_stimulus(1'b1, OP_DIV, 8'd200, 8'd7, 1'b0);
        apply_stimulus(1'b1, OP_DIV, 8'd255, 8'd0, 1'b0);
        apply_stimulus(1'b1, OP_SUB, 8'd0, 8'd255, 1'b0);

        // start held high: add finishes, sub is accepted in the DONE cycle
        sel_wide  = 1'b0;
        start_drv = 1'b1;
        op_drv    = OP_ADD;
        a_drv     = 8'd2;
        b_drv     = 8'd3;
        @(posedge clk); #1;
        op_drv = OP_SUB;
        a_drv  = 8'd1;
        b_drv  = 8'd4;
        @(posedge clk); #1;
        check_output("b2b_first_done", 16'(done4), 16'd1);
        check_output("b2b_first_result", {8'h00, result4}, 16'h0005);
        @(posedge clk); #1;
        check_output("b2b_second_busy", 16'(busy4), 16'd1);
        check_output("b2b_second_cleared", {8'h00, result4}, 16'd0);
        start_drv = 1'b0;
        @(posedge clk); #1;
        check_output("b2b_second_done", 16'(done4), 16'd1);
        check_output("b2b_second_result", {8'h00, result4}, 16'h00FD);
        check_output("b2b_second_neg", 16'(neg4), 16'd1);
        @(posedge clk); #1;

        // reset in the middle of a multiply
        start_drv = 1'b1;
        op_drv    = OP_MUL;
        a_drv     = 8'd13;
        b_drv     = 8'd11;
        @(posedge clk); #1;
        start_drv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_output("midreset_busy", 16'(busy4), 16'd0);
        check_output("midreset_done", 16'(done4), 16'd0);
        check_output("midreset_result", {8'h00, result4}, 16'd0);
        rst     = 1'b1;
        no_done = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (done4 || busy4) no_done = 1'b0;
        end
        check_output("midreset_no_done", 16'(no_done), 16'd1);

        for (int n = 0; n < 30; n++) begin
            apply_stimulus(1'b0, 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        end
        for (int n = 0; n < 15; n++) begin
            apply_stimulus(1'b1, 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
